// File: rtl/param_shift_reg_unit.sv
// WIDTH-bit storage register with parallel load and a multi-cycle shift/rotate engine.
// One 1-bit step per clock under a start/busy/done handshake.
module param_shift_reg_unit #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             Clk,
  input  logic             synch_reset,
  input  logic [WIDTH-1:0] D,
  input  logic             load,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic             serial_in,
  output logic [WIDTH-1:0] Q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

  state_t           r_state, w_state_d;
  logic [WIDTH-1:0] r_q, w_q_d, w_step_q;
  logic             r_so, w_so_d, w_step_so;
  logic [CNT_W-1:0] r_rem, w_rem_d;
  logic [2:0]       r_mode, w_mode_d;

  // One step of the latched mode; the departing bit becomes serial_out.
  always_comb begin
    w_step_q  = r_q;
    w_step_so = r_so;
    unique case (r_mode)
      3'b000: begin w_step_q = {r_q[WIDTH-2:0], serial_in};  w_step_so = r_q[WIDTH-1]; end
      3'b001: begin w_step_q = {serial_in, r_q[WIDTH-1:1]};  w_step_so = r_q[0];       end
      3'b010: begin w_step_q = {r_q[WIDTH-2:0], r_q[WIDTH-1]}; w_step_so = r_q[WIDTH-1]; end
      3'b011: begin w_step_q = {r_q[0], r_q[WIDTH-1:1]};     w_step_so = r_q[0];       end
      3'b100: begin w_step_q = {r_q[WIDTH-1], r_q[WIDTH-1:1]}; w_step_so = r_q[0];     end
      3'b101: begin w_step_q = {r_q[WIDTH-2:0], 1'b0};       w_step_so = r_q[WIDTH-1]; end
      3'b110: begin w_step_q = {1'b0, r_q[WIDTH-1:1]};       w_step_so = r_q[0];       end
      default: begin w_step_q = r_q;                         w_step_so = r_so;         end
    endcase
  end

  always_comb begin
    w_state_d = r_state;
    w_q_d     = r_q;
    w_so_d    = r_so;
    w_rem_d   = r_rem;
    w_mode_d  = r_mode;
    unique case (r_state)
      StIdle: begin
        if (load) begin
          w_q_d = D;
        end else if (start) begin
          w_mode_d = mode;
          if (amount == '0) begin
            w_state_d = StDone;
          end else begin
            w_rem_d   = amount;
            w_state_d = StShift;
          end
        end
      end
      StShift: begin
        w_q_d   = w_step_q;
        w_so_d  = w_step_so;
        w_rem_d = r_rem - CNT_W'(1);
        if (r_rem == CNT_W'(1)) w_state_d = StDone;
      end
      StDone:  w_state_d = StIdle;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (synch_reset) begin
      r_state <= StIdle;
      r_q     <= '0;
      r_so    <= 1'b0;
      r_rem   <= '0;
      r_mode  <= '0;
    end else begin
      r_state <= w_state_d;
      r_q     <= w_q_d;
      r_so    <= w_so_d;
      r_rem   <= w_rem_d;
      r_mode  <= w_mode_d;
    end
  end

  assign Q          = r_q;
  assign serial_out = r_so;
  assign busy       = (r_state == StShift);
  assign done       = (r_state == StDone);

endmodule
